reflet_bus_responder: RTL

Memory-side responder for the `reflet_cpu` data bus. It answers the CPU's `addr`/`data_out`/`write_en` accesses with a synchronous RAM, and exposes two memory-mapped registers at the top of the address space: a status register and a write-only TX port. The TX port feeds a small FIFO that drains through a valid/ready handshake toward a debug sink such as a UART or a testbench monitor. It replaces ad-hoc ROM models in simulations and sits directly beside the CPU in top-level integrations.

---
 rtl/reflet_bus_responder_pkg.sv | 18 +
 rtl/reflet_bus_responder_if.sv | 36 +++
 rtl/reflet_bus_responder_fifo.sv | 61 ++++++
 rtl/reflet_bus_responder.sv | 96 +++++++++
 4 files changed

// File: rtl/reflet_bus_responder_pkg.sv
// Shared constants for the reflet bus responder:
// register addresses and STATUS bit positions.
package reflet_bus_responder_pkg;

   localparam int FULL    = 0;
   localparam int EMPTY   = 1;
   localparam int OVF     = 2;
   localparam int CNT_LSB = 3;

   function automatic int tx_addr(input int ws);
      return (2 ** ws) - 1;
   endfunction

   function automatic int status_addr(input int ws);
      return (2 ** ws) - 2;
   endfunction

endpackage

// File: rtl/reflet_bus_responder_if.sv
// CPU data bus plus TX valid/ready stream
// between the CPU side and the responder.
interface reflet_bus_responder_if #(
   parameter int wordsize = 8
);
   import reflet_bus_responder_pkg::*;

   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] data_in;
   logic                write_en;
   logic [wordsize-1:0] data_out;
   logic [wordsize-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;

   modport master (
      output addr,
      output data_in,
      output write_en,
      output tx_ready,
      input  data_out,
      input  tx_data,
      input  tx_valid
   );

   modport slave (
      input  addr,
      input  data_in,
      input  write_en,
      input  tx_ready,
      output data_out,
      output tx_data,
      output tx_valid
   );

endinterface

// File: rtl/reflet_bus_responder_fifo.sv
// Small TX FIFO with wrapping pointers; head
// is read combinationally from storage.
module reflet_fifo
   import reflet_bus_responder_pkg::*;
#(
   parameter int width      = 8,
   parameter int depth_log2 = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [width-1:0]      push_data,
   input  logic                  pop,
   output logic [width-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [depth_log2:0]   count
);

   localparam int DEPTH = 2 ** depth_log2;
   localparam logic [depth_log2:0] FULL_CNT =
      (depth_log2 + 1)'(DEPTH);

   logic [width-1:0]      storage [DEPTH];
   logic [depth_log2-1:0] wr_ptr;
   logic [depth_log2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A pop in the same cycle frees the slot, so a full push is legal.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head = empty ? '0 : storage[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         storage[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/reflet_bus_responder.sv
// Memory-side responder: synchronous RAM, STATUS
// register and a FIFO-backed TX port.
module reflet_bus_responder
   import reflet_bus_responder_pkg::*;
#(
   parameter int    wordsize        = 8,
   parameter int    fifo_depth_log2 = 2,
   parameter string init_file       = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   reflet_bus_responder_if.slave   bus
);

   localparam int RAM_WORDS = (2 ** wordsize) - 2;
   localparam logic [wordsize-1:0] TX_ADDR =
      wordsize'(tx_addr(wordsize));
   localparam logic [wordsize-1:0] STATUS_ADDR =
      wordsize'(status_addr(wordsize));

   logic [wordsize-1:0]        mem [RAM_WORDS];
   logic [wordsize-1:0]        rd_data;
   logic [wordsize-1:0]        status_word;
   logic [wordsize-1:0]        head;
   logic [fifo_depth_log2:0]   count;
   logic                       full;
   logic                       empty;
   logic                       ovf;
   logic                       is_tx;
   logic                       is_status;
   logic                       is_ram;
   logic                       push_req;
   logic                       pop;

   assign is_tx     = (bus.addr == TX_ADDR);
   assign is_status = (bus.addr == STATUS_ADDR);
   assign is_ram    = (bus.addr < STATUS_ADDR);

   assign push_req = bus.write_en & is_tx;
   assign pop      = bus.tx_valid & bus.tx_ready;

   reflet_fifo #(
      .width      (wordsize),
      .depth_log2 (fifo_depth_log2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (bus.data_in),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign bus.tx_valid = ~empty;
   assign bus.tx_data  = head;

   always_comb begin
      status_word = '0;
      status_word[FULL]  = full;
      status_word[EMPTY] = empty;
      status_word[OVF]   = ovf;
      status_word[CNT_LSB +: fifo_depth_log2 + 1] = count;
   end

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         is_tx:     rd_data = '0;
         is_status: rd_data = status_word;
         is_ram:    rd_data = mem[bus.addr];
      endcase
   end

   // STATUS is sampled here, before this edge's push/pop lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.data_out <= '0;
         ovf          <= 1'b0;
      end else begin
         bus.data_out <= rd_data;
         if (push_req && full && !pop)
            ovf <= 1'b1;
         else if (bus.write_en && is_status)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.write_en && is_ram)
         mem[bus.addr] <= bus.data_in;
   end

endmodule
